// File: rtl/if_stage.sv
// Instruction-fetch stage: program counter, instruction-memory address and IF/ID register.
// Optional IF_STAGE_PERF_CNT_EN adds saturating stall/flush event counters.
module if_stage #(
  parameter int              ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [18:0]     NOP_INSTR = 19'd0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              PCwrite,
  input  logic              IF_IDwrite,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [18:0]       imem_data,
  output logic [18:0]       IF_ID_instr,
  output logic [ADDR_W-1:0] IF_ID_pc,
  output logic              IF_ID_valid,
  output logic [2:0]        IF_rs,
  output logic [2:0]        IF_rt,
  output logic [1:0]        fetch_state
`ifdef IF_STAGE_PERF_CNT_EN
  ,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       flush_cnt
`endif
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t            state_reg;
  logic [ADDR_W-1:0] pc_reg, pc_next, pc_inc;
  logic [18:0]       instr_reg, instr_next;
  logic [ADDR_W-1:0] ifid_pc_reg, ifid_pc_next;
  logic              valid_reg, valid_next;

  assign pc_inc = pc_reg + 1'b1;

  always_comb begin
    pc_next = pc_reg;
    if (branch_taken)
      pc_next = branch_target;
    else if (PCwrite && (state_reg != BOOT))
      pc_next = pc_inc;
  end

  // A taken branch squashes the wrong-path instruction regardless of the stall enables.
  always_comb begin
    instr_next   = instr_reg;
    ifid_pc_next = ifid_pc_reg;
    valid_next   = valid_reg;
    if (branch_taken) begin
      instr_next   = NOP_INSTR;
      ifid_pc_next = '0;
      valid_next   = 1'b0;
    end else if (IF_IDwrite && (state_reg != BOOT)) begin
      instr_next   = imem_data;
      ifid_pc_next = pc_inc;
      valid_next   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= BOOT;
      pc_reg      <= RESET_PC;
      instr_reg   <= NOP_INSTR;
      ifid_pc_reg <= '0;
      valid_reg   <= 1'b0;
    end else begin
      pc_reg      <= pc_next;
      instr_reg   <= instr_next;
      ifid_pc_reg <= ifid_pc_next;
      valid_reg   <= valid_next;
      if (branch_taken) begin
        state_reg <= FLUSH;
      end else begin
        case (state_reg)
          BOOT:    state_reg <= RUN;
          RUN:     state_reg <= (!PCwrite && !IF_IDwrite) ? STALL : RUN;
          STALL:   state_reg <= (PCwrite || IF_IDwrite) ? RUN : STALL;
          default: state_reg <= RUN;
        endcase
      end
    end
  end

  assign imem_addr   = pc_reg;
  assign IF_ID_instr = instr_reg;
  assign IF_ID_pc    = ifid_pc_reg;
  assign IF_ID_valid = valid_reg;
  assign fetch_state = state_reg;

  // Register-specifier fields handed back to hazard detection.
  for (genvar gi = 0; gi < 3; gi++) begin : g_fields
    assign IF_rs[gi] = instr_reg[11+gi];
    assign IF_rt[gi] = instr_reg[8+gi];
  end

`ifdef IF_STAGE_PERF_CNT_EN
  logic [15:0] stall_cnt_reg, flush_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_reg <= 16'd0;
      flush_cnt_reg <= 16'd0;
    end else begin
      if ((state_reg == STALL) && (stall_cnt_reg != 16'hFFFF))
        stall_cnt_reg <= stall_cnt_reg + 16'd1;
      if (branch_taken && (flush_cnt_reg != 16'hFFFF))
        flush_cnt_reg <= flush_cnt_reg + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;
`endif

endmodule
